pr_bus_arbiter: RTL and testbench
=================================

# pr_bus_arbiter

Arbitrates the processor peripheral bus (PrAddr/PrWD/PrBE/IOWrite/PrRD) between two masters: the CPU MEM stage and a DMA engine. Sequences each access through a grant/access/acknowledge FSM, inserts wait states until the addressed device signals ready, and stalls the CPU pipeline while its access is pending. Sits between `mips` and the device bridge, so the CPU no longer drives the device bus directly.

## Interface
- TIMEOUT, 16, cycles in ACCESS without `dev_ready` before abort (2..255)
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- cpu_req  in  1  CPU access request; held stable until `cpu_ack`
- cpu_addr  in  30  CPU word address [31:2]
- cpu_wd  in  32  CPU write data
- cpu_be  in  4  CPU byte enables
- cpu_we  in  1  1 = write, 0 = read
- cpu_stall  out  1  `cpu_req & ~cpu_ack` (combinational); freezes pipeline
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rd  out  32  read data, valid while `cpu_ack`=1
- cpu_err  out  1  with `cpu_ack`: access timed out
- dma_req, dma_addr[29:0], dma_wd[31:0], dma_be[3:0], dma_we  in  DMA request set, same rules as CPU
- dma_ack, dma_rd[31:0], dma_err  out  DMA completion set, same rules as CPU
- PrAddr  out  30  device word address
- PrWD  out  32  device write data
- PrBE  out  4  device byte enables
- IOWrite  out  1  device write strobe
- PrStrobe  out  1  access valid on bus
- PrRD  in  32  device read data, sampled when `dev_ready`=1
- dev_ready  in  1  device completes the current access this cycle

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: if any request, latch winner's addr/wd/be/we into bus registers, set `owner`, go ACCESS. Otherwise stay.
- Arbitration: single requester wins. When both request, the master not granted last wins (round-robin via `last_owner`). After reset, `last_owner`=DMA, so CPU wins the first tie.
- ACCESS: `PrStrobe`=1, bus outputs from latched registers, `IOWrite`=`we`. When `dev_ready`=1, capture `PrRD` (zero for writes) into the owner's rd register, go ACK. Wait counter increments each ACCESS cycle without ready.
- ACK: owner's `*_ack`=1 for exactly this cycle, rd/err valid; `last_owner`←owner; go IDLE. ACK→IDLE costs one cycle; the next grant is decided in IDLE.
- Outside ACCESS: PrAddr, PrWD, PrBE, IOWrite, PrStrobe all 0.
- Requester deasserting before ack: illegal; access still completes and acks.
- Requests arriving during ACCESS/ACK are ignored until IDLE.
- Non-owner `*_ack`/`*_err` stay 0; its rd holds its last value.

## Timing
- Reset values: state=IDLE, all bus outputs 0, cpu_ack/dma_ack/cpu_err/dma_err 0, cpu_rd/dma_rd 0, wait counter 0, `last_owner`=DMA. Reset mid-access aborts with no ack.
- Requests are sampled at the rising edge in IDLE. Request at edge N (state IDLE) → ACCESS from N+1.
- `dev_ready` in the first ACCESS cycle gives ACK in cycle N+2, so the minimum latency from request to ack is 2 cycles. Each cycle of `dev_ready` delay adds 1 cycle.
- Back-to-back by the same master: next request is seen in IDLE at N+3. Minimum period is 3 cycles.
- `cpu_stall` is combinational, with no register delay from `cpu_req`.

## Configuration
- `PR_ARB_TIMEOUT_EN` defined: if the counter reaches TIMEOUT in ACCESS without `dev_ready`, go ACK with `*_err`=1 and `*_rd`=32'h0. `dev_ready` arriving in the same cycle as the limit wins, with no error.
- Undefined: no counter; ACCESS waits indefinitely for `dev_ready`. `*_err` is tied to 0.

## Test plan
- CPU read, `dev_ready` in the first ACCESS cycle with PrRD=32'h1234_5678, after req at cycle 0 → PrStrobe=1 in cycle 1, cpu_ack=1 with cpu_rd=32'h1234_5678 in cycle 2, cpu_stall=1 in cycles 0–1 and 0 in cycle 2.
- DMA write addr=30'h40, wd=32'hA5A5_0000, be=4'b1100, ready after 3 wait cycles → IOWrite=1 with matching PrAddr/PrWD/PrBE for 4 cycles, dma_ack 5 cycles after req, cpu signals untouched.
- Both requesting continuously from reset → grant order CPU, DMA, CPU, DMA, with acks spaced 3 cycles apart when ready is immediate.
- With `PR_ARB_TIMEOUT_EN`, TIMEOUT=16 and `dev_ready` held 0 → cpu_ack=1, cpu_err=1, cpu_rd=0 after 16 ACCESS cycles; bus outputs return to 0 in ACK. Without the macro, no ack after 100 cycles.
- Assert rst=0 during ACCESS → all outputs 0 immediately (asynchronously), no ack. After release, a simultaneous CPU+DMA request grants CPU first.

Source files
------------

// File: rtl/pr_bus_arbiter.sv
// rtl/pr_bus_arbiter.sv - CPU/DMA peripheral bus arbiter with grant/access/ack FSM and wait states
// Optional access timeout: define PR_ARB_TIMEOUT_EN.
module pr_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_we,
  output logic        cpu_stall,
  output logic        cpu_ack,
  output logic [31:0] cpu_rd,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic [29:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic [3:0]  dma_be,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [31:0] dma_rd,
  output logic        dma_err,
  output logic [29:0] PrAddr,
  output logic [31:0] PrWD,
  output logic [3:0]  PrBE,
  output logic        IOWrite,
  output logic        PrStrobe,
  input  logic [31:0] PrRD,
  input  logic        dev_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic OWN_DMA = 1'b1;

  generate
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("pr_bus_arbiter: TIMEOUT must lie in 2..255");
    end
  endgenerate

  state_t      r_state;
  logic        r_owner;
  logic        r_last_owner;
  logic [29:0] r_pr_addr;
  logic [31:0] r_pr_wd;
  logic [3:0]  r_pr_be;
  logic        r_io_write;
  logic        r_pr_strobe;
  logic        r_cpu_ack;
  logic        r_dma_ack;
  logic        r_cpu_err;
  logic        r_dma_err;
  logic [31:0] r_cpu_rd;
  logic [31:0] r_dma_rd;

  logic        w_grant_dma;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_fin_rd;

`ifdef PR_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT - 1);
  logic [7:0] r_wait_cnt;
  assign w_timeout = ~dev_ready & (r_wait_cnt == TIMEOUT_CNT);
`else
  assign w_timeout = 1'b0;
`endif

  // On a tie, the master that did not own the previous access wins.
  assign w_grant_dma = dma_req & (~cpu_req | (r_last_owner != OWN_DMA));
  assign w_done      = dev_ready | w_timeout;
  assign w_fin_rd    = (dev_ready & ~r_io_write) ? PrRD : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= OWN_DMA;
      r_pr_addr    <= '0;
      r_pr_wd      <= '0;
      r_pr_be      <= '0;
      r_io_write   <= 1'b0;
      r_pr_strobe  <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dma_err    <= 1'b0;
      r_cpu_rd     <= '0;
      r_dma_rd     <= '0;
`ifdef PR_ARB_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req | dma_req) begin
            r_owner     <= w_grant_dma;
            r_pr_addr   <= w_grant_dma ? dma_addr : cpu_addr;
            r_pr_wd     <= w_grant_dma ? dma_wd   : cpu_wd;
            r_pr_be     <= w_grant_dma ? dma_be   : cpu_be;
            r_io_write  <= w_grant_dma ? dma_we   : cpu_we;
            r_pr_strobe <= 1'b1;
`ifdef PR_ARB_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_done) begin
            // Bus registers double as the latched request, so clearing them idles the bus.
            r_pr_addr   <= '0;
            r_pr_wd     <= '0;
            r_pr_be     <= '0;
            r_io_write  <= 1'b0;
            r_pr_strobe <= 1'b0;
            if (r_owner == OWN_DMA) begin
              r_dma_ack <= 1'b1;
              r_dma_rd  <= w_fin_rd;
              r_dma_err <= w_timeout;
            end else begin
              r_cpu_ack <= 1'b1;
              r_cpu_rd  <= w_fin_rd;
              r_cpu_err <= w_timeout;
            end
            r_state <= S_ACK;
          end
`ifdef PR_ARB_TIMEOUT_EN
          else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        S_ACK: begin
          r_cpu_ack    <= 1'b0;
          r_dma_ack    <= 1'b0;
          r_cpu_err    <= 1'b0;
          r_dma_err    <= 1'b0;
          r_last_owner <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PrAddr    = r_pr_addr;
  assign PrWD      = r_pr_wd;
  assign PrBE      = r_pr_be;
  assign IOWrite   = r_io_write;
  assign PrStrobe  = r_pr_strobe;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rd    = r_cpu_rd;
  assign cpu_err   = r_cpu_err;
  assign dma_ack   = r_dma_ack;
  assign dma_rd    = r_dma_rd;
  assign dma_err   = r_dma_err;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb/tb_pr_bus_arbiter.sv - scoreboard bench for pr_bus_arbiter
module tb_pr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [29:0] cpu_addr = '0;
  logic [31:0] cpu_wd = '0;
  logic [3:0]  cpu_be = '0;
  logic        cpu_stall, cpu_ack, cpu_err;
  logic [31:0] cpu_rd;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [29:0] dma_addr = '0;
  logic [31:0] dma_wd = '0;
  logic [3:0]  dma_be = '0;
  logic        dma_ack, dma_err;
  logic [31:0] dma_rd;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        IOWrite, PrStrobe;
  logic [31:0] PrRD = '0;
  logic        dev_ready = 1'b0;

  pr_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_be(cpu_be), .cpu_we(cpu_we),
    .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rd(cpu_rd), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wd(dma_wd), .dma_be(dma_be), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_rd(dma_rd), .dma_err(dma_err),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE), .IOWrite(IOWrite), .PrStrobe(PrStrobe),
    .PrRD(PrRD), .dev_ready(dev_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [29:0] addr; logic [31:0] wd; logic [3:0] be; logic we; int len; } bus_t;
  typedef struct { logic dma; logic [31:0] rd; logic err; int cyc; } ack_t;
  typedef struct { int waits; logic [31:0] data; } dev_t;

  bus_t bus_q[$];
  ack_t ack_q[$];
  dev_t dev_q[$];

  int n_pass = 0, n_total = 0, n_acks = 0;
  logic [31:0] last_cpu_rd = '0, last_dma_rd = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [159:0] all_outs();
    return {PrStrobe, IOWrite, PrAddr, PrWD, PrBE, cpu_ack, dma_ack, cpu_err, dma_err, cpu_rd, dma_rd};
  endfunction

  task automatic expect_xfer(input logic dma, input logic [29:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic we, input int waits,
                             input logic [31:0] data, input int ack_cyc);
    bus_q.push_back('{a, wd, be, we, waits + 1});
    dev_q.push_back('{waits, data});
    ack_q.push_back('{dma, we ? 32'h0 : data, 1'b0, ack_cyc});
  endtask

  task automatic drive_cpu(input logic [29:0] a, input logic [31:0] wd, input logic [3:0] be, input logic we);
    cpu_req = 1'b1; cpu_addr = a; cpu_wd = wd; cpu_be = be; cpu_we = we;
  endtask

  task automatic drive_dma(input logic [29:0] a, input logic [31:0] wd, input logic [3:0] be, input logic we);
    dma_req = 1'b1; dma_addr = a; dma_wd = wd; dma_be = be; dma_we = we;
  endtask

  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Device model: answers each strobed access after the queued number of wait cycles.
  initial begin
    dev_t cur;
    int   cnt = 0;
    bit   active = 0;
    cur = '{0, 32'h0};
    forever begin
      @(negedge clk);
      if (!PrStrobe) begin
        active = 0;
        dev_ready = 1'b0;
      end else begin
        if (!active) begin
          if (dev_q.size() != 0) cur = dev_q.pop_front();
          else cur = '{1 << 30, 32'h0};
          active = 1;
          cnt = 0;
        end
        if (cnt == cur.waits) begin
          dev_ready = 1'b1;
          PrRD = cur.data;
        end else begin
          dev_ready = 1'b0;
          PrRD = $urandom;
          cnt++;
        end
      end
    end
  end

  // Monitor: checks bus contents/length per access and every ack against the scoreboard.
  initial begin
    bus_t cur;
    ack_t e;
    int   slen = 0;
    bit   prev_strobe = 0;
    cur = '{'0, '0, '0, 1'b0, -1};
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_strobe = 0;
        continue;
      end
      if (PrStrobe) begin
        if (!prev_strobe) begin
          if (bus_q.size() == 0) begin
            chk("bus_unexpected", PrStrobe, 1'b0);
            cur.len = -1;
          end else begin
            cur = bus_q.pop_front();
          end
          slen = 0;
        end
        slen++;
        chk("bus_fields", {PrAddr, PrWD, PrBE, IOWrite}, {cur.addr, cur.wd, cur.be, cur.we});
      end else if (prev_strobe && cur.len >= 0) begin
        chk("strobe_len", slen, cur.len);
      end
      prev_strobe = PrStrobe;

      if (cpu_ack || dma_ack) begin
        n_acks++;
        chk("ack_exclusive", {cpu_ack, dma_ack} == 2'b11, 1'b0);
        chk("bus_idle_in_ack", {PrStrobe, IOWrite, PrAddr, PrWD, PrBE}, 0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", {cpu_ack, dma_ack}, 0);
        end else begin
          e = ack_q.pop_front();
          chk("ack_master", dma_ack, e.dma);
          chk("ack_cycle", cyc, e.cyc);
          if (e.dma) begin
            chk("dma_rd", dma_rd, e.rd);
            chk("dma_err", dma_err, e.err);
            chk("cpu_untouched", {cpu_ack, cpu_err, cpu_rd}, {2'b00, last_cpu_rd});
            last_dma_rd = e.rd;
          end else begin
            chk("cpu_rd", cpu_rd, e.rd);
            chk("cpu_err", cpu_err, e.err);
            chk("dma_untouched", {dma_ack, dma_err, dma_rd}, {2'b00, last_dma_rd});
            last_cpu_rd = e.rd;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk("reset_outputs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    at(cyc + 1);
    chk("idle_outputs", {all_outs(), cpu_stall}, 0);

    // CPU read, immediate ready
    c = cyc;
    expect_xfer(1'b0, 30'h100, 32'h0, 4'hF, 1'b0, 0, 32'h1234_5678, c + 2);
    drive_cpu(30'h100, 32'h0, 4'hF, 1'b0);
    #1 chk("stall_c0", cpu_stall, 1'b1);
    at(c + 1);
    @(negedge clk) chk("stall_c1", {cpu_stall, PrStrobe}, 2'b11);
    at(c + 2);
    @(negedge clk) chk("stall_at_ack", {cpu_stall, cpu_ack}, 2'b01);
    at(c + 3);
    cpu_req = 1'b0;

    // DMA write, three wait states
    c = cyc;
    expect_xfer(1'b1, 30'h40, 32'hA5A5_0000, 4'b1100, 1'b1, 3, 32'hDEAD_BEEF, c + 5);
    drive_dma(30'h40, 32'hA5A5_0000, 4'b1100, 1'b1);
    at(c + 6);
    dma_req = 1'b0;

    // Both requesting continuously: CPU, DMA, CPU, DMA, acks 3 cycles apart
    c = cyc;
    expect_xfer(1'b0, 30'h200, 32'h0, 4'hF, 1'b0, 0, 32'h1111_1111, c + 2);
    expect_xfer(1'b1, 30'h300, 32'h0, 4'hF, 1'b0, 0, 32'h2222_2222, c + 5);
    expect_xfer(1'b0, 30'h201, 32'h3333_3333, 4'b0011, 1'b1, 0, 32'h5555_5555, c + 8);
    expect_xfer(1'b1, 30'h301, 32'h4444_4444, 4'hF, 1'b1, 0, 32'h6666_6666, c + 11);
    drive_cpu(30'h200, 32'h0, 4'hF, 1'b0);
    drive_dma(30'h300, 32'h0, 4'hF, 1'b0);
    at(c + 3);
    drive_cpu(30'h201, 32'h3333_3333, 4'b0011, 1'b1);
    at(c + 6);
    drive_dma(30'h301, 32'h4444_4444, 4'hF, 1'b1);
    at(c + 12);
    cpu_req = 1'b0;
    dma_req = 1'b0;

    // Ready in the 16th access cycle: normal completion in either build
    at(cyc + 1);
    c = cyc;
    expect_xfer(1'b0, 30'h3FFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b0, 15, 32'hCAFE_F00D, c + 17);
    drive_cpu(30'h3FFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b0);
    at(c + 18);
    cpu_req = 1'b0;

    // Device never ready
    at(cyc + 1);
    c = cyc;
`ifdef PR_ARB_TIMEOUT_EN
    bus_q.push_back('{30'h55, 32'h0, 4'hF, 1'b0, 16});
    dev_q.push_back('{100000, 32'h7777_7777});
    ack_q.push_back('{1'b0, 32'h0, 1'b1, c + 17});
    drive_cpu(30'h55, 32'h0, 4'hF, 1'b0);
    at(c + 18);
    cpu_req = 1'b0;
    at(cyc + 1);
    c = cyc;
    bus_q.push_back('{30'h66, 32'h9, 4'h1, 1'b1, -1});
    dev_q.push_back('{100000, 32'h0});
    drive_cpu(30'h66, 32'h9, 4'h1, 1'b1);
    at(c + 5);
`else
    begin
      int acks0;
      bus_q.push_back('{30'h55, 32'h0, 4'hF, 1'b0, -1});
      dev_q.push_back('{100000, 32'h7777_7777});
      drive_cpu(30'h55, 32'h0, 4'hF, 1'b0);
      acks0 = n_acks;
      at(c + 100);
      chk("no_ack_without_timeout", n_acks - acks0, 0);
    end
`endif

    // Asynchronous reset in the middle of an access
    #2 chk("in_access_before_reset", PrStrobe, 1'b1);
    rst = 1'b0;
    cpu_req = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 0);
    last_cpu_rd = '0;
    last_dma_rd = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    at(cyc + 1);

    // Simultaneous request after reset: CPU granted first
    c = cyc;
    expect_xfer(1'b0, 30'h10, 32'h0, 4'hF, 1'b0, 0, 32'h600D_F00D, c + 2);
    expect_xfer(1'b1, 30'h20, 32'h0BAD_CAFE, 4'b0101, 1'b1, 0, 32'h1357_9BDF, c + 5);
    drive_cpu(30'h10, 32'h0, 4'hF, 1'b0);
    drive_dma(30'h20, 32'h0BAD_CAFE, 4'b0101, 1'b1);
    at(c + 3);
    cpu_req = 1'b0;
    at(c + 6);
    dma_req = 1'b0;

    at(cyc + 5);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("dev_queue_drained", dev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
